// File: rtl/spi_master_gen2.sv
// spi_master_gen2: parametrised SPI master with a per-transfer CPOL/CPHA
// setting and one-hot, active-low slave selects.
//
// Parameters: WIDTH (bits per transfer, 2..32), HALFDIV (Clk_i cycles per
// SCK half-period, >=1), NSLAVES (select lines, 1..16).
// Optional feature: define SPIM_LSB_FIRST_EN to add the Lsb_i input, which
// selects LSB-first shifting per transfer. Without it, transfers are always
// MSB first.
//
// Ports:
//   Clk_i, Rst_ni   clock (rising edge) and asynchronous active-low reset
//   Valid_i/Ready_o request handshake. A transfer is accepted on a Clk_i edge
//                   where Valid_i && Ready_o. Ready_o is high only in IDLE.
//                   Data_i, Sel_i, Cpol_i, Cpha_i (and Lsb_i) are sampled on
//                   that edge and are don't-care otherwise.
//   Done_o          one-cycle pulse at completion; Rcvd_o updates with it
//   Sck_o, Mosi_o   registered SPI clock and data out
//   Miso_i          SPI data in
//   Ss_no           registered one-hot active-low selects
module spi_master_gen2 #(
  parameter int WIDTH   = 8,
  parameter int HALFDIV = 2,
  parameter int NSLAVES = 4,
  localparam int SELW   = $clog2(NSLAVES > 1 ? NSLAVES : 2)
) (
  input  logic               Clk_i,
  input  logic               Rst_ni,
  input  logic               Valid_i,
  output logic               Ready_o,
  input  logic [WIDTH-1:0]   Data_i,
  input  logic [SELW-1:0]    Sel_i,
  input  logic               Cpol_i,
  input  logic               Cpha_i,
`ifdef SPIM_LSB_FIRST_EN
  input  logic               Lsb_i,
`endif
  output logic               Done_o,
  output logic [WIDTH-1:0]   Rcvd_o,
  output logic               Sck_o,
  output logic               Mosi_o,
  input  logic               Miso_i,
  output logic [NSLAVES-1:0] Ss_no
);

  localparam int HW = $clog2(HALFDIV + 1);
  localparam int KW = $clog2(2 * WIDTH);
  localparam logic [HW-1:0] HLAST = HW'(HALFDIV - 1);
  localparam logic [KW-1:0] KLAST = KW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t           state;
  logic [HW-1:0]    hcnt;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_nxt;
  logic             cpol_q;
  logic             cpha_q;
  logic             lsb_q;
  logic             lsb_in;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [NSLAVES-1:0] sel_dec;

`ifdef SPIM_LSB_FIRST_EN
  assign lsb_in = Lsb_i;
`else
  assign lsb_in = 1'b0;
`endif

  assign Ready_o = (state == IDLE);
  assign k_nxt   = k + KW'(1);

  // Out-of-range indices match no line, so every select stays high.
  always_comb begin
    sel_dec = '1;
    for (int i = 0; i < NSLAVES; i++) begin
      if (32'(Sel_i) == 32'(i)) sel_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state  <= IDLE;
      hcnt   <= '0;
      k      <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      tx     <= '0;
      rx     <= '0;
      Done_o <= 1'b0;
      Rcvd_o <= '0;
      Sck_o  <= 1'b0;
      Mosi_o <= 1'b0;
      Ss_no  <= '1;
    end else begin
      Done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid_i) begin
            state  <= LEAD;
            hcnt   <= '0;
            k      <= '0;
            cpol_q <= Cpol_i;
            cpha_q <= Cpha_i;
            lsb_q  <= lsb_in;
            Sck_o  <= Cpol_i;
            Ss_no  <= sel_dec;
            // Bit 0 goes out now; tx holds the remaining bits, pre-shifted.
            Mosi_o <= lsb_in ? Data_i[0] : Data_i[WIDTH-1];
            tx     <= lsb_in ? (Data_i >> 1) : (Data_i << 1);
          end
        end
        LEAD: begin
          if (hcnt == HLAST) begin
            hcnt  <= '0;
            k     <= '0;
            state <= XFER;
            Sck_o <= cpol_q ^ cpha_q;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        XFER: begin
          if (hcnt == HLAST) begin
            hcnt <= '0;
            if (k == KLAST) begin
              state <= TRAIL;
              Sck_o <= cpol_q;
            end else begin
              k     <= k_nxt;
              Sck_o <= cpol_q ^ cpha_q ^ k_nxt[0];
              if (k_nxt[0]) begin
                // Second half of a bit: sample MISO.
                rx <= lsb_q ? {Miso_i, rx[WIDTH-1:1]} : {rx[WIDTH-2:0], Miso_i};
              end else begin
                // First half of the next bit: present it on MOSI.
                Mosi_o <= lsb_q ? tx[0] : tx[WIDTH-1];
                tx     <= lsb_q ? (tx >> 1) : (tx << 1);
              end
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        TRAIL: begin
          if (hcnt == HLAST) begin
            hcnt   <= '0;
            state  <= IDLE;
            Done_o <= 1'b1;
            Rcvd_o <= rx;
            Ss_no  <= '1;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// Directed testbench for spi_master_gen2 (WIDTH=8, HALFDIV=2). A second
// instance with NSLAVES=3 covers the out-of-range select case. Outputs are
// sampled on the falling clock edge; sample n is taken after the n-th rising
// edge following the accepting edge (n=0 right after acceptance).
module tb_spi_master_gen2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid, ready, cpol, cpha, done, sck, mosi, miso, lsb;
  logic [7:0] data, rcvd;
  logic [1:0] sel;
  logic [3:0] ss;

  logic       valid3, ready3, done3, sck3, mosi3;
  logic [7:0] data3, rcvd3;
  logic [1:0] sel3;
  logic [2:0] ss3;
  logic       zero = 1'b0;

  spi_master_gen2 #(.WIDTH(8), .HALFDIV(2), .NSLAVES(4)) dut (
    .Clk_i(clk), .Rst_ni(rst_n), .Valid_i(valid), .Ready_o(ready),
    .Data_i(data), .Sel_i(sel), .Cpol_i(cpol), .Cpha_i(cpha),
`ifdef SPIM_LSB_FIRST_EN
    .Lsb_i(lsb),
`endif
    .Done_o(done), .Rcvd_o(rcvd), .Sck_o(sck), .Mosi_o(mosi),
    .Miso_i(miso), .Ss_no(ss)
  );

  spi_master_gen2 #(.WIDTH(8), .HALFDIV(2), .NSLAVES(3)) dut3 (
    .Clk_i(clk), .Rst_ni(rst_n), .Valid_i(valid3), .Ready_o(ready3),
    .Data_i(data3), .Sel_i(sel3), .Cpol_i(zero), .Cpha_i(zero),
`ifdef SPIM_LSB_FIRST_EN
    .Lsb_i(zero),
`endif
    .Done_o(done3), .Rcvd_o(rcvd3), .Sck_o(sck3), .Mosi_o(mosi3),
    .Miso_i(zero), .Ss_no(ss3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Results of the most recent do_xfer call.
  int         r_cycles, r_rises, r_ss_bad, r_ready_bad;
  logic [7:0] r_rcvd, r_mosi;
  logic       r_mosi0, r_sck0;
  logic [3:0] r_ss0, r_ss_done;

  // Runs one transfer on dut. lb=1 loops MOSI back to MISO, otherwise a
  // mode-0 slave shifts out sword MSB first, advancing after each rising SCK.
  // hold=1 keeps Valid_i high with next_d for a back-to-back request.
  task automatic do_xfer(input logic [7:0] d, input logic [1:0] s,
                         input logic pol, input logic pha, input logic l,
                         input bit lb, input logic [7:0] sword,
                         input logic [3:0] ss_exp, input bit hold,
                         input logic [7:0] next_d);
    int   rises;
    logic prev_sck;
    bit   fin;
    valid = 1'b1; data = d; sel = s; cpol = pol; cpha = pha; lsb = l;
    miso = lb ? mosi : sword[7];
    r_cycles = 0; r_ss_bad = 0; r_ready_bad = 0; r_mosi = '0;
    rises = 0; fin = 1'b0; prev_sck = sck;
    for (int n = 0; n < 200 && !fin; n++) begin
      @(negedge clk);
      if (n == 0) begin
        if (hold) data = next_d;
        else valid = 1'b0;
        r_sck0 = sck; r_mosi0 = mosi; r_ss0 = ss;
      end else if (sck && !prev_sck) begin
        rises++;
        r_mosi = {r_mosi[6:0], mosi};
      end
      prev_sck = sck;
      if (done) begin
        fin = 1'b1; r_cycles = n; r_rcvd = rcvd; r_ss_done = ss;
      end else begin
        if (ss !== ss_exp) r_ss_bad++;
        if (ready !== 1'b0) r_ready_bad++;
      end
      miso = lb ? mosi : (rises < 8 ? sword[7 - rises] : 1'b0);
    end
    r_rises = rises;
  endtask

  initial begin
    int bad3, cyc3, dcount;
    bit fin3;
    rst_n = 1'b0; valid = 1'b0; data = '0; sel = '0; cpol = 1'b0; cpha = 1'b0;
    lsb = 1'b0; miso = 1'b0; valid3 = 1'b0; data3 = '0; sel3 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rcvd", rcvd, 8'h00);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ss", ss, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0 basic transfer, slave returns 0x3C
    do_xfer(8'hA5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 4'b1101, 1'b0, 8'h00);
    check("m0_cycles", r_cycles, 36);
    check("m0_rcvd", r_rcvd, 8'h3C);
    check("m0_mosi_seq", r_mosi, 8'hA5);
    check("m0_rises", r_rises, 8);
    check("m0_ss_bad", r_ss_bad, 0);
    check("m0_ready_bad", r_ready_bad, 0);
    check("m0_ss_done", r_ss_done, 4'hF);
    check("m0_mosi_lead", r_mosi0, 1'b1);
    @(negedge clk);
    check("m0_done_pulse", done, 1'b0);
    check("m0_rcvd_hold", rcvd, 8'h3C);
    check("m0_ready_after", ready, 1'b1);

    // Mode 3 loopback
    do_xfer(8'h81, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'b1011, 1'b0, 8'h00);
    check("m3_sck_lead", r_sck0, 1'b1);
    check("m3_rises", r_rises, 8);
    check("m3_mosi_seq", r_mosi, 8'h81);
    check("m3_rcvd", r_rcvd, 8'h81);
    check("m3_cycles", r_cycles, 36);
    check("m3_ss_bad", r_ss_bad, 0);
    @(negedge clk);
    check("m3_sck_idle", sck, 1'b1);

    // Back-to-back, mode 0 loopback; SCK returns to CPOL=0 on entering LEAD
    do_xfer(8'h12, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b1110, 1'b1, 8'h34);
    check("b2b1_sck_lead", r_sck0, 1'b0);
    check("b2b1_rcvd", r_rcvd, 8'h12);
    check("b2b1_cycles", r_cycles, 36);
    check("b2b1_ss_done", r_ss_done, 4'hF);
    check("b2b1_ready_done", ready, 1'b1);
    do_xfer(8'h34, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b1110, 1'b0, 8'h00);
    check("b2b2_ss_first", r_ss0, 4'b1110);
    check("b2b2_rcvd", r_rcvd, 8'h34);
    check("b2b2_cycles", r_cycles, 36);
    check("b2b2_ss_bad", r_ss_bad, 0);

    // Out-of-range select on the 3-slave instance
    valid3 = 1'b1; data3 = 8'h55; sel3 = 2'd3;
    bad3 = 0; cyc3 = 0; fin3 = 1'b0;
    for (int n = 0; n < 200 && !fin3; n++) begin
      @(negedge clk);
      if (n == 0) valid3 = 1'b0;
      if (ss3 !== 3'b111) bad3++;
      if (done3) begin fin3 = 1'b1; cyc3 = n; end
    end
    check("oor_ss_bad", bad3, 0);
    check("oor_cycles", cyc3, 36);

    // Reset mid-transfer at sample 10
    valid = 1'b1; data = 8'hF0; sel = 2'd1; cpol = 1'b0; cpha = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (n == 0) valid = 1'b0;
      miso = mosi;
    end
    check("mid_mosi_before", mosi, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_ready", ready, 1'b1);
    check("mid_done", done, 1'b0);
    check("mid_rcvd", rcvd, 8'h00);
    check("mid_ss", ss, 4'hF);
    check("mid_mosi", mosi, 1'b0);
    check("mid_sck", sck, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mid_no_done", dcount, 0);
    do_xfer(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0111, 1'b0, 8'h00);
    check("post_rst_rcvd", r_rcvd, 8'h5A);
    check("post_rst_cycles", r_cycles, 36);

`ifdef SPIM_LSB_FIRST_EN
    // LSB first loopback
    @(negedge clk);
    do_xfer(8'h01, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'b1101, 1'b0, 8'h00);
    check("lsb_mosi_lead", r_mosi0, 1'b1);
    check("lsb_mosi_seq", r_mosi, 8'h80);
    check("lsb_rcvd", r_rcvd, 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_gen2.md
# spi_master_gen2

Parametrised SPI master, the successor to the fixed 8-bit, mode-0 master. Word width, SCK divider and slave-select count are compile-time parameters. SPI mode (CPOL/CPHA) is chosen per transfer. A valid/ready handshake and a single-cycle completion pulse replace the strobe/ready pair. The block sits between a local controller and the off-chip SPI pins, drives one-hot active-low selects, and returns the received word on every transfer.

## Interface
- WIDTH, 8: bits per transfer, legal range 2..32.
- HALFDIV, 2: Clk_i cycles per SCK half-period, ≥1.
- NSLAVES, 4: number of select lines, 1..16.
- SELW (localparam) = $clog2(NSLAVES>1 ? NSLAVES : 2).
- Clk_i  in  1  system clock; all logic on its rising edge.
- Rst_ni  in  1  asynchronous, active-low reset.
- Valid_i  in  1  request to start a transfer.
- Ready_o  out  1  block idle and able to accept.
- Data_i  in  WIDTH  word to transmit.
- Sel_i  in  SELW  slave index.
- Cpol_i  in  1  SCK idle level for this transfer.
- Cpha_i  in  1  clock phase for this transfer.
- Done_o  out  1  one-cycle pulse when the transfer completes.
- Rcvd_o  out  WIDTH  received word; updated only when Done_o pulses.
- Sck_o  out  1  SPI clock, registered.
- Mosi_o  out  1  serial data out, registered.
- Miso_i  in  1  serial data in.
- Ss_no  out  NSLAVES  active-low selects, registered.

## Operation
- **Accept:** a transfer is accepted when Valid_i && Ready_o at a Clk_i edge. On acceptance the block latches Data_i, Sel_i, Cpol_i and Cpha_i. Inputs are don't-care at all other times.
- **States:**
  - IDLE → LEAD on accept.
  - LEAD → XFER after HALFDIV cycles.
  - XFER → TRAIL after 2·WIDTH half-periods.
  - TRAIL → IDLE after HALFDIV cycles.
- **Counters:** a half-period counter hcnt runs 0..HALFDIV-1 and wraps. A half-period index k runs 0..2·WIDTH-1 and advances on each hcnt wrap in XFER.
- **Selects:** in LEAD, XFER and TRAIL, Ss_no[sel] = 0 and all other lines are 1.
  - If sel ≥ NSLAVES, all lines stay 1. The transfer still runs and Done_o still pulses.
  - In IDLE all lines are 1.
- **SCK:** equals the latched CPOL in IDLE, LEAD and TRAIL. In XFER, Sck_o = CPOL ^ CPHA ^ k[0].
- **Data bits:** bit i occupies half-periods k=2i and 2i+1.
  - Mosi_o presents bit i from the start of k=2i. For i=0 this means from the start of LEAD.
  - Miso_i is sampled into the receive shift register on the Clk_i edge that begins k=2i+1.
- **Bit order:** MSB first (bit 0 = Data_i[WIDTH-1]) unless SPIM_LSB_FIRST_EN is defined.
- **Idle outputs:** Mosi_o holds its last value in IDLE.
- **Completion:** on TRAIL→IDLE, Rcvd_o is loaded from the shift register and Done_o = 1 for that one cycle.
- **Ready_o:** equals (state == IDLE). It is combinational from the state register.

## Timing
- **Reset values:** Ready_o=1, Done_o=0, Rcvd_o=0, Sck_o=0, Mosi_o=0, Ss_no=all 1. State is IDLE and latched CPOL=0.
- **Reset mid-transfer:** the block returns to reset values immediately, asynchronously, with no Done_o.
- **Latency:** from the accepting edge to the edge that asserts Done_o is (2·WIDTH+2)·HALFDIV cycles. Ss_no asserts one edge after acceptance.
- **Back-to-back:** Done_o and Ready_o are high together. A Valid_i in that cycle is accepted and starts LEAD on the next edge. Select lines return to 1 for at least that one cycle between transfers.
- **Mode change between transfers:** Sck_o moves to the new CPOL on the edge entering LEAD, i.e. before the first SCK edge.
- **HALFDIV=1:** legal. SCK runs at Clk_i/2.
- **Counter widths:** hcnt is $clog2(HALFDIV+1) bits; k is $clog2(2·WIDTH) bits. Neither counter may overflow.

## Configuration
- SPIM_LSB_FIRST_EN
  - **Defined:** adds input port Lsb_i (1 bit), latched on accept. When Lsb_i=1, transmit and receive are LSB first: bit 0 = Data_i[0], and the first received bit lands in Rcvd_o[0]. When Lsb_i=0, MSB first.
  - **Undefined:** no Lsb_i port; always MSB first.

## Test plan
- **Mode 0, basic transfer:** WIDTH=8, HALFDIV=2, Cpol=0, Cpha=0, Data_i=0xA5, Sel_i=1; slave model returns 0x3C.
  - Ss_no=4'b1101 from edge 1 to edge 36.
  - Mosi_o bit sequence is 1,0,1,0,0,1,0,1.
  - 8 rising SCK edges occur.
  - Done_o pulses at cycle 36 with Rcvd_o=0x3C.
- **Mode 3:** Cpol=1, Cpha=1, Data_i=0x81; loopback Miso_i=Mosi_o.
  - Sck_o idles at 1.
  - MISO is sampled on the rising SCK edges.
  - Rcvd_o=0x81.
- **Back-to-back:** Valid_i held high for two words, 0x12 then 0x34.
  - The second word is accepted in the Done_o cycle.
  - Ss_no goes high for exactly 1 cycle between the two transfers.
  - Rcvd_o updates twice.
- **Out-of-range select:** NSLAVES=3, Sel_i=3.
  - Ss_no stays 3'b111 throughout.
  - Done_o still pulses after 36 cycles.
- **Reset mid-transfer:** Rst_ni=0 at cycle 10 of a transfer.
  - All outputs take their reset values immediately and Ready_o=1.
  - No Done_o pulse.
  - The next transfer completes normally.
- **LSB first (macro defined):** Lsb_i=1, Data_i=0x01, loopback.
  - The first Mosi_o bit is 1.
  - Rcvd_o=0x01.
